// File: rtl/grostl_inv_sub_bytes_seq_m.sv
// rtl/grostl_inv_sub_bytes_seq_m.sv - masked inverse SubBytes over 8 bytes, one shared S-box
// The S-box sees a byte unmasked only combinationally; every register holds masked data or masks.

module bsbox (
  input  logic       encrypt,
  input  logic [7:0] a,
  output logic [7:0] q
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] b;
    p = 8'h00;
    b = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ b;
      b = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // x^254 equals the multiplicative inverse in GF(2^8), and maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] s;
    logic [7:0] r;
    s = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] aff_fwd(input logic [7:0] x);
    logic [7:0] b;
    for (int i = 0; i < 8; i++)
      b[i] = x[i] ^ x[(i + 4) % 8] ^ x[(i + 5) % 8] ^ x[(i + 6) % 8] ^ x[(i + 7) % 8];
    return b ^ 8'h63;
  endfunction

  function automatic logic [7:0] aff_inv(input logic [7:0] x);
    logic [7:0] b;
    for (int i = 0; i < 8; i++)
      b[i] = x[(i + 2) % 8] ^ x[(i + 5) % 8] ^ x[(i + 7) % 8];
    return b ^ 8'h05;
  endfunction

  logic [7:0] pre;
  logic [7:0] inv_v;

  always_comb begin
    pre   = encrypt ? a : aff_inv(a);
    inv_v = gf_inv(pre);
    q     = encrypt ? aff_fwd(inv_v) : inv_v;
  end

endmodule

module grostl_inv_sub_bytes_seq_m (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] din,
  input  logic [63:0] imask,
  input  logic [63:0] omask,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] dout,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  idx;
  logic [63:0] din_r;
  logic [63:0] imask_r;
  logic [63:0] omask_r;
  logic [5:0]  bit_lo;
  logic [7:0]  sbox_in;
  logic [7:0]  sbox_out;

  // byte 0 sits in the top bits, so byte idx starts at bit 8*(7-idx)
  assign bit_lo  = {3'd7 - idx, 3'b000};
  assign sbox_in = din_r[bit_lo +: 8] ^ imask_r[bit_lo +: 8];

  bsbox u_bsbox (
    .encrypt (1'b0),
    .a       (sbox_in),
    .q       (sbox_out)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (idx == 3'd7) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx     <= 3'd0;
      din_r   <= 64'h0;
      imask_r <= 64'h0;
      omask_r <= 64'h0;
      dout    <= 64'h0;
    end else if (state == IDLE && in_valid) begin
      idx     <= 3'd0;
      din_r   <= din;
      imask_r <= imask;
      omask_r <= omask;
    end else if (state == RUN) begin
      dout[bit_lo +: 8] <= sbox_out ^ omask_r[bit_lo +: 8];
      if (idx != 3'd7) idx <= idx + 3'd1;
    end
  end

endmodule

// File: tb/tb_grostl_inv_sub_bytes_seq_m.sv
// tb/tb_grostl_inv_sub_bytes_seq_m.sv - scoreboard bench for grostl_inv_sub_bytes_seq_m
// Reference inverse S-box is built from a generator-based forward S-box, then inverted.

module tb_grostl_inv_sub_bytes_seq_m;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] din;
  logic [63:0] imask;
  logic [63:0] omask;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] dout;
  logic        busy;

  grostl_inv_sub_bytes_seq_m dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .imask     (imask),
    .omask     (omask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [7:0]  inv_tab [256];
  logic [63:0] sb_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] w;
    w = {v, v} << n;
    return w[15:8];
  endfunction

  task automatic build_tables();
    logic [7:0] sb [256];
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] x;
    p = 8'h01;
    q = 8'h01;
    for (int k = 0; k < 255; k++) begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1B : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sb[p] = x ^ 8'h63;
    end
    sb[0] = 8'h63;
    for (int i = 0; i < 256; i++) inv_tab[sb[i]] = 8'(i);
  endtask

  function automatic logic [63:0] model(input logic [63:0] d, input logic [63:0] im,
                                        input logic [63:0] om);
    logic [63:0] r;
    for (int b = 0; b < 8; b++)
      r[8*b +: 8] = inv_tab[d[8*b +: 8] ^ im[8*b +: 8]] ^ om[8*b +: 8];
    return r;
  endfunction

  // Samples handshakes mid-cycle, then advances one rising edge and settles.
  task automatic tick();
    logic [63:0] e;
    @(negedge clk);
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) chk("pop_on_empty_queue", 64'd1, 64'd0);
      else begin
        e = sb_q.pop_front();
        chk("dout_vs_model", dout, e);
      end
    end
    if (!reset && in_valid && in_ready) sb_q.push_back(model(din, imask, omask));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    if (!out_valid) chk(tag, 64'd0, 64'd1);
  endtask

  logic [63:0] held;
  int sent;
  int cyc;

  initial begin
    build_tables();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    din = '0; imask = '0; omask = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_dout", dout, 64'h0);

    // zero masks, latency and handshake timing
    din = 64'h637C000000000000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("accept_busy", 64'(busy), 64'd1);
    chk("run_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 7; i++) tick();
    chk("lat7_out_valid", 64'(out_valid), 64'd0);
    tick();
    chk("lat8_out_valid", 64'(out_valid), 64'd1);
    chk("zero_mask_const", dout, 64'h0001525252525252);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_done_in_ready", 64'(in_ready), 64'd1);
    chk("post_done_out_valid", 64'(out_valid), 64'd0);

    // masked block
    din = {8{8'h48}}; imask = {8{8'hA5}}; omask = {8{8'h3C}}; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out("masked_timeout");
    chk("masked_const", dout, {8{8'h6F}});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // back-pressure with an ignored in_valid during DONE
    din = 64'h0123456789ABCDEF; imask = 64'hFEDCBA9876543210; omask = 64'h55AA55AA0F0FF0F0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out("bp_timeout");
    held = dout;
    din = 64'hDEADBEEFDEADBEEF; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_dout_stable", dout, held);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    chk("bp_queue_empty", 64'(sb_q.size()), 64'd0);

    // reset on the 4th RUN cycle, then accept on the first cycle reset is low
    din = 64'h1122334455667788; imask = 64'h99; omask = 64'h77; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    sb_q.delete();
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_dout", dout, 64'h0);
    reset = 1'b0; out_ready = 1'b0;
    din = 64'hA0B1C2D3E4F50617; imask = 64'h0F1E2D3C4B5A6978; omask = 64'h8899AABBCCDDEEFF;
    tick();
    in_valid = 1'b0;
    chk("first_cycle_accept", 64'(busy), 64'd1);
    wait_out("fresh_timeout");
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // random regression with valid/ready stalls
    sent = 0;
    cyc  = 0;
    while ((sent < 1500 || sb_q.size() != 0 || busy) && cyc < 60000) begin
      if (in_ready && in_valid) sent++;
      in_valid  = (sent < 1500) && ($urandom_range(0, 3) != 0);
      din       = {$urandom, $urandom};
      imask     = {$urandom, $urandom};
      omask     = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("rand_drained", 64'(sb_q.size()), 64'd0);
    chk("rand_no_timeout", 64'(cyc < 60000), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
